// File: rtl/ex_stage_md_if.sv
// Bundles the execute-stage input op, the valid/ready handshakes and the result
// bus. The upstream/downstream side uses master; the stage itself uses slave.
interface ex_stage_md_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] data_a;
  logic [XLEN-1:0] data_b;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] pc;
  logic            asel;
  logic            bsel;
  logic [4:0]      alu_sel;
  logic            br_un;
  logic [2:0]      branch;
  logic            jump;
  logic            md_en;
  logic [2:0]      md_op;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic [XLEN-1:0] wr_data;
  logic            pc_sel;
  logic            busy;

  modport master (
    output in_valid, data_a, data_b, imm, pc, asel, bsel, alu_sel, br_un,
           branch, jump, md_en, md_op, out_ready,
    input  in_ready, out_valid, result, wr_data, pc_sel, busy
  );

  modport slave (
    input  in_valid, data_a, data_b, imm, pc, asel, bsel, alu_sel, br_un,
           branch, jump, md_en, md_op, out_ready,
    output in_ready, out_valid, result, wr_data, pc_sel, busy
  );
endinterface

// File: rtl/ex_stage_md.sv
// Execute stage: single-cycle ALU/branch plus an iterative one-bit-per-cycle
// RV32M/RV64M multiply/divide unit, all feeding one registered output.
module ex_stage_md #(
  parameter int XLEN = 32
) (
  input logic          clk,
  input logic          rst_n,
  input logic          flush,
  ex_stage_md_if.slave bus
);
  localparam int SW = $clog2(XLEN);
  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic {S_IDLE, S_CALC} state_t;

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_op;
  logic [XLEN-1:0]   r_a, r_b, r_mag_b;
  logic [2*XLEN-1:0] r_acc;
  logic              r_neg_q, r_a_neg;
  logic              r_valid, r_pc_sel;
  logic [XLEN-1:0]   r_result, r_wr_data;

  logic w_busy, w_done, w_accept;
  assign w_busy   = (r_state == S_CALC);
  assign w_done   = w_busy && (r_cnt == '0);
  assign w_accept = bus.in_valid && bus.in_ready;

  assign bus.in_ready  = !flush && !w_busy && (!r_valid || bus.out_ready);
  assign bus.busy      = w_busy;
  assign bus.out_valid = r_valid;
  assign bus.result    = r_result;
  assign bus.wr_data   = r_wr_data;
  assign bus.pc_sel    = r_pc_sel;

  // ALU
  logic [XLEN-1:0] w_op_a, w_op_b, w_alu_res;
  logic [SW-1:0]   w_shamt;
  assign w_op_a  = bus.asel ? bus.pc  : bus.data_a;
  assign w_op_b  = bus.bsel ? bus.imm : bus.data_b;
  assign w_shamt = w_op_b[SW-1:0];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_alu_res = '0;
    case (bus.alu_sel)
      5'd0:  w_alu_res = w_op_a + w_op_b;
      5'd1:  w_alu_res = w_op_a - w_op_b;
      5'd2:  w_alu_res = w_op_a << w_shamt;
      5'd3:  w_alu_res = {{(XLEN-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
      5'd4:  w_alu_res = {{(XLEN-1){1'b0}}, (w_op_a < w_op_b)};
      5'd5:  w_alu_res = w_op_a ^ w_op_b;
      5'd6:  w_alu_res = w_op_a >> w_shamt;
      5'd7:  w_alu_res = $signed(w_op_a) >>> w_shamt;
      5'd8:  w_alu_res = w_op_a | w_op_b;
      5'd9:  w_alu_res = w_op_a & w_op_b;
      5'd10: w_alu_res = w_op_b;
      default: w_alu_res = '0;
    endcase
  end

  // Branch resolution always compares the register operands, never pc/imm.
  logic w_eq, w_lt, w_taken, w_pc_sel;
  assign w_eq = (bus.data_a == bus.data_b);
  assign w_lt = bus.br_un ? (bus.data_a < bus.data_b)
                          : ($signed(bus.data_a) < $signed(bus.data_b));

  always_comb begin
    w_taken = 1'b0;
    case (bus.branch)
      3'd1: w_taken = w_eq;
      3'd2: w_taken = !w_eq;
      3'd3: w_taken = w_lt;
      3'd4: w_taken = !w_lt;
      default: w_taken = 1'b0;
    endcase
  end
  assign w_pc_sel = !bus.md_en && (bus.jump || w_taken);

  // Operand magnitudes and sign flags captured at accept
  logic            w_a_neg, w_b_neg;
  logic [XLEN-1:0] w_mag_a, w_mag_b;
  assign w_a_neg = (bus.md_op inside {3'd1, 3'd2, 3'd4, 3'd6}) && bus.data_a[XLEN-1];
  assign w_b_neg = (bus.md_op inside {3'd1, 3'd4, 3'd6}) && bus.data_b[XLEN-1];
  assign w_mag_a = w_a_neg ? -bus.data_a : bus.data_a;
  assign w_mag_b = w_b_neg ? -bus.data_b : bus.data_b;

  // Shift-add step: {hi, lo} where lo shifts out multiplier bits LSB first.
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_acc;
  assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_mag_b} : '0);
  assign w_mul_acc = {w_mul_sum, r_acc[XLEN-1:1]};

  // Restoring step: {remainder, dividend/quotient}; quotient bits enter at the LSB.
  logic [XLEN:0]     w_div_shift;
  logic [XLEN-1:0]   w_div_diff, w_rem_nxt;
  logic              w_div_ge;
  logic [2*XLEN-1:0] w_div_acc;
  assign w_div_shift = r_acc[2*XLEN-1:XLEN-1];
  assign w_div_ge    = (w_div_shift >= {1'b0, r_mag_b});
  assign w_div_diff  = w_div_shift[XLEN-1:0] - r_mag_b;
  assign w_rem_nxt   = w_div_ge ? w_div_diff : w_div_shift[XLEN-1:0];
  assign w_div_acc   = {w_rem_nxt, r_acc[XLEN-2:0], w_div_ge};

  // Sign correction and special cases, applied on the completion edge
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo, w_rem, w_md_res;
  logic              w_b_zero;
  assign w_prod   = r_neg_q ? -r_acc : r_acc;
  assign w_quo    = r_neg_q ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem    = r_a_neg ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
  assign w_b_zero = (r_b == '0);

  always_comb begin
    w_md_res = '0;
    case (r_op)
      3'd0:             w_md_res = w_prod[XLEN-1:0];
      3'd1, 3'd2, 3'd3: w_md_res = w_prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:       w_md_res = w_b_zero ? '1 : w_quo;
      default:          w_md_res = w_b_zero ? r_a : w_rem;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept && bus.md_en) w_state_nxt = S_CALC;
      S_CALC: if (w_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) w_state_nxt = S_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_mag_b <= '0;
      r_acc   <= '0;
      r_neg_q <= 1'b0;
      r_a_neg <= 1'b0;
    end else if (flush) begin
      r_cnt <= '0;
    end else if (w_accept && bus.md_en) begin
      r_cnt   <= CW'(XLEN);
      r_op    <= bus.md_op;
      r_a     <= bus.data_a;
      r_b     <= bus.data_b;
      r_mag_b <= w_mag_b;
      r_acc   <= {{XLEN{1'b0}}, w_mag_a};
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_a_neg <= w_a_neg;
    end else if (w_busy && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
      r_acc <= r_op[2] ? w_div_acc : w_mul_acc;
    end
  end

  // A completion or a new ALU op takes priority over the consume that clears out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_result  <= '0;
      r_wr_data <= '0;
      r_pc_sel  <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_done) begin
      r_valid   <= 1'b1;
      r_result  <= w_md_res;
      r_wr_data <= r_b;
      r_pc_sel  <= 1'b0;
    end else if (w_accept && !bus.md_en) begin
      r_valid   <= 1'b1;
      r_result  <= w_alu_res;
      r_wr_data <= bus.data_b;
      r_pc_sel  <= w_pc_sel;
    end else if (bus.out_ready) begin
      r_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ex_stage_md.sv
// Scoreboard bench for ex_stage_md: directed ops push expected results at
// accept; a negedge monitor pops and compares each consumed output.
module tb_ex_stage_md;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  ex_stage_md_if #(.XLEN(XLEN)) bus ();
  ex_stage_md #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus));

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] wd;
    logic        ps;
    logic [15:0] tag;
  } exp_t;

  exp_t sb_q[$];
  exp_t m_e;
  int   n_checks = 0;
  int   n_fail = 0;
  int   tag = 0;
  int   last_wait = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        check("spurious_output", 32'(bus.out_valid), 32'd0);
      end else begin
        m_e = sb_q.pop_front();
        check($sformatf("result#%0d", m_e.tag), bus.result, m_e.res);
        check($sformatf("wr_data#%0d", m_e.tag), bus.wr_data, m_e.wd);
        check($sformatf("pc_sel#%0d", m_e.tag), 32'(bus.pc_sel), 32'(m_e.ps));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                       input logic [31:0] p, input logic as, input logic bs,
                       input logic [4:0] al, input logic bu, input logic [2:0] brc,
                       input logic jp, input logic me, input logic [2:0] mo,
                       input logic [31:0] er, input logic eps, input bit push);
    int n;
    exp_t e;
    n = 0;
    bus.data_a = a; bus.data_b = b; bus.imm = im; bus.pc = p;
    bus.asel = as; bus.bsel = bs; bus.alu_sel = al; bus.br_un = bu;
    bus.branch = brc; bus.jump = jp; bus.md_en = me; bus.md_op = mo;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    last_wait = n;
    if (!bus.in_ready) begin
      check("accept_timeout", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (push) begin
      e.res = er; e.wd = b; e.ps = eps; e.tag = 16'(tag);
      sb_q.push_back(e);
    end
    tag++;
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic alu(input logic [31:0] a, input logic [31:0] b, input logic [4:0] sel,
                     input logic [31:0] er);
    issue(a, b, 32'd0, 32'd0, 1'b0, 1'b0, sel, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, er, 1'b0, 1'b1);
  endtask

  task automatic br(input logic [31:0] a, input logic [31:0] b, input logic bu,
                    input logic [2:0] brc, input logic jp, input logic eps);
    issue(a, b, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, bu, brc, jp, 1'b0, 3'd0, a + b, eps, 1'b1);
  endtask

  // Branch/jump are set on mul/div ops to confirm they are ignored.
  task automatic md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] er, input bit push);
    issue(a, b, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 3'd1, 1'b1, 1'b1, op, er, 1'b0, push);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || bus.out_valid) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bit seen_ready;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.data_a = '0; bus.data_b = '0; bus.imm = '0; bus.pc = '0;
    bus.asel = 1'b0; bus.bsel = 1'b0; bus.alu_sel = '0; bus.br_un = 1'b0;
    bus.branch = '0; bus.jump = 1'b0; bus.md_en = 1'b0; bus.md_op = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_wr_data", bus.wr_data, 32'd0);
    check("rst_pc_sel", 32'(bus.pc_sel), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    #1 check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // ALU ops, back to back
    alu(32'd5, 32'd7, 5'd0, 32'd12);
    alu(32'h8000_0000, 32'd4, 5'd7, 32'hF800_0000);
    alu(32'd3, 32'd9, 5'd15, 32'd0);
    alu(32'd3, 32'd5, 5'd1, 32'hFFFF_FFFE);
    alu(32'd1, 32'd33, 5'd2, 32'd2);
    alu(32'hFFFF_FFFF, 32'd1, 5'd3, 32'd1);
    alu(32'hFFFF_FFFF, 32'd1, 5'd4, 32'd0);
    alu(32'h0000_F0F0, 32'h0000_FF00, 5'd5, 32'h0000_0FF0);
    alu(32'h8000_0000, 32'd4, 5'd6, 32'h0800_0000);
    alu(32'h0000_00F0, 32'h0000_000F, 5'd8, 32'h0000_00FF);
    alu(32'h0000_00F0, 32'h0000_003C, 5'd9, 32'h0000_0030);
    issue(32'd1, 32'd2, 32'h0000_1234, 32'd0, 1'b0, 1'b1, 5'd10, 1'b0, 3'd0, 1'b0,
          1'b0, 3'd0, 32'h0000_1234, 1'b0, 1'b1);
    issue(32'd0, 32'h55, 32'd4, 32'h100, 1'b1, 1'b1, 5'd0, 1'b0, 3'd0, 1'b1,
          1'b0, 3'd0, 32'h104, 1'b1, 1'b1);

    // Branches
    br(32'hFFFF_FFFF, 32'd1, 1'b0, 3'd3, 1'b0, 1'b1);
    br(32'hFFFF_FFFF, 32'd1, 1'b1, 3'd3, 1'b0, 1'b0);
    br(32'hFFFF_FFFF, 32'd1, 1'b0, 3'd4, 1'b0, 1'b0);
    br(32'd5, 32'd5, 1'b0, 3'd1, 1'b0, 1'b1);
    br(32'd5, 32'd5, 1'b0, 3'd2, 1'b0, 1'b0);
    br(32'd5, 32'd5, 1'b0, 3'd5, 1'b0, 1'b0);
    drain();

    // MULH latency and in_ready while iterating
    md(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b1);
    n = 0;
    seen_ready = 1'b0;
    while (!bus.out_valid && n < 100) begin
      if (bus.in_ready) seen_ready = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    check("md_latency", 32'(n), 32'd33);
    check("in_ready_low_calc", 32'(seen_ready), 32'd0);

    md(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
    md(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1);
    md(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1'b1);
    md(3'd3, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b1);
    md(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    md(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1);
    md(3'd5, 32'd7, 32'd0, 32'hFFFF_FFFF, 1'b1);
    md(3'd7, 32'd7, 32'd0, 32'd7, 1'b1);
    md(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b1);
    md(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b1);
    md(3'd4, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 1'b1);
    md(3'd6, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b1);
    drain();

    // Backpressure: output held, no accept, then 1 op/cycle on release
    bus.out_ready = 1'b0;
    alu(32'd10, 32'd20, 5'd0, 32'd30);
    bus.data_a = 32'd100; bus.data_b = 32'd1; bus.alu_sel = 5'd1; bus.in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_result_hold", bus.result, 32'd30);
      check("bp_wr_data_hold", bus.wr_data, 32'd20);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    alu(32'd100, 32'd1, 5'd1, 32'd99);
    alu(32'd6, 32'd3, 5'd9, 32'd2);
    check("b2b_wait_c", 32'(last_wait), 32'd0);
    alu(32'd6, 32'd3, 5'd8, 32'd7);
    check("b2b_wait_d", 32'(last_wait), 32'd0);
    drain();

    // Flush at CALC cycle 10
    md(3'd4, 32'd100, 32'd7, 32'd0, 1'b0);
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    #1 check("flush_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_busy", 32'(bus.busy), 32'd0);
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    md(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b1);
    drain();

    // Asynchronous reset mid-divide
    md(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b1);
    drain();
    md(3'd5, 32'd100, 32'd7, 32'd0, 1'b0);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_result", bus.result, 32'd0);
    check("arst_wr_data", bus.wr_data, 32'd0);
    check("arst_busy", 32'(bus.busy), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    md(3'd5, 32'd100, 32'd7, 32'd14, 1'b1);
    md(3'd7, 32'd100, 32'd7, 32'd2, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
